// File: rtl/orb_pkg.sv
// Shared constants and fill-state encoding for the orbit frame buffer.
// The serializer-side blocks import the same package.
package orb_pkg;

    localparam int ORB_W          = 12;
    localparam int ORB_DEPTH_LOG2 = 11;
    localparam int ORB_BANK_WORDS = 2048;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        FULL = 2'd3
    } fill_state_t;

    // One-hot grant presented while the fill machine sits in a given state.
    function automatic logic [1:0] grant_of(fill_state_t s);
        case (s)
            GNT0:    grant_of = 2'b01;
            GNT1:    grant_of = 2'b10;
            default: grant_of = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/orb_rr_arb2.sv
// Two-way round-robin pick: prio=0 favours requester 0, prio=1 favours requester 1.
// prio_next hands priority to whichever requester did not win.
module orb_rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] pick,
    output logic       prio_next
);

    always_comb begin
        pick      = 2'b00;
        prio_next = prio;
        if (req[0] && (!req[1] || !prio)) begin
            pick      = 2'b01;
            prio_next = 1'b1;
        end else if (req[1]) begin
            pick      = 2'b10;
            prio_next = 1'b0;
        end
    end

endmodule

// File: rtl/orb_buf_fill_arb.sv
// Write-side scheduler for the ping-pong orbit frame buffer: arbitrates two word
// streams in bursts and fills the bank opposite the one the serializer is reading.
module orb_buf_fill_arb
    import orb_pkg::*;
#(
    parameter int W          = ORB_W,
    parameter int DEPTH_LOG2 = ORB_DEPTH_LOG2,
    parameter int BURST      = 16
) (
    input  logic                  iClkOrb,
    input  logic                  reset,
    input  logic                  iSwitch,
    input  logic [1:0]            iReq,
    input  logic [1:0]            iVal,
    input  logic [W-1:0]          iData0,
    input  logic [W-1:0]          iData1,
    output logic [1:0]            oGnt,
    output logic                  oWrEn,
    output logic [DEPTH_LOG2:0]   oWrAddr,
    output logic [W-1:0]          oWrData,
    output logic                  oFull,
    output logic                  oUnderrun,
    output logic [DEPTH_LOG2:0]   oFillLast
);

    localparam int              PW        = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0]   LAST_IDX  = PW'(2**DEPTH_LOG2 - 1);
    localparam logic [7:0]      LAST_BEAT = 8'(BURST - 1);

    fill_state_t   state, state_next;
    logic [1:0]    gnt_next;
    logic [PW-1:0] ptr;
    logic [7:0]    beat;
    logic          prio, prio_pick;
    logic [1:0]    pick;
    logic          sw_prev, sw_primed;
    logic          swap, accept, hit_full, burst_done, req_drop;
    logic [W-1:0]  acc_data;

    orb_rr_arb2 u_arb (
        .req       (iReq),
        .prio      (prio),
        .pick      (pick),
        .prio_next (prio_pick)
    );

    // sw_primed stands in for capturing iSwitch at reset: the first edge only loads sw_prev.
    assign swap       = sw_primed & (iSwitch ^ sw_prev);
    assign accept     = |(oGnt & iVal);
    assign acc_data   = (oGnt[1] & iVal[1]) ? iData1 : iData0;
    assign hit_full   = accept & (ptr == LAST_IDX);
    assign burst_done = accept & (beat == LAST_BEAT);
    assign req_drop   = |(oGnt & ~iReq);

    always_ff @(posedge iClkOrb or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (swap) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!oFull && pick[0])      state_next = GNT0;
                    else if (!oFull && pick[1]) state_next = GNT1;
                end
                GNT0, GNT1: begin
                    if (hit_full)                    state_next = FULL;
                    else if (burst_done || req_drop) state_next = IDLE;
                end
                FULL:    state_next = FULL;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        gnt_next = grant_of(state_next);
    end

    // A word accepted in the swap cycle lands at index 0 of the freshly released bank.
    always_ff @(posedge iClkOrb or negedge reset) begin
        if (!reset) begin
            oGnt      <= 2'b00;
            oWrEn     <= 1'b0;
            oWrAddr   <= '0;
            oWrData   <= '0;
            oFull     <= 1'b0;
            oUnderrun <= 1'b0;
            oFillLast <= '0;
            ptr       <= '0;
            beat      <= '0;
            prio      <= 1'b0;
            sw_prev   <= 1'b0;
            sw_primed <= 1'b0;
        end else begin
            sw_prev   <= iSwitch;
            sw_primed <= 1'b1;
            oGnt      <= gnt_next;
            oWrEn     <= accept;
            oUnderrun <= swap & ~oFull;
            if (accept) begin
                oWrData <= acc_data;
                oWrAddr <= {~iSwitch, swap ? {DEPTH_LOG2{1'b0}} : ptr[DEPTH_LOG2-1:0]};
            end
            if (swap) begin
                oFillLast <= ptr;
                oFull     <= 1'b0;
                ptr       <= accept ? PW'(1) : '0;
            end else begin
                if (accept)   ptr   <= ptr + 1'b1;
                if (hit_full) oFull <= 1'b1;
            end
            if (state_next != state) beat <= '0;
            else if (accept)         beat <= beat + 1'b1;
            if (state == IDLE && (state_next == GNT0 || state_next == GNT1))
                prio <= prio_pick;
        end
    end

endmodule

// File: tb/tb_orb_buf_fill_arb.sv
// Randomized scoreboard bench for orb_buf_fill_arb with a word-level reference model.
module tb_orb_buf_fill_arb;
    import orb_pkg::*;

    localparam int BURST = 16;

    typedef struct {
        logic [1:0]  gnt;
        logic        wr_en;
        logic        full;
        logic        underrun;
        logic [11:0] fill_last;
    } status_t;

    typedef struct {
        logic [11:0] addr;
        logic [11:0] data;
    } write_t;

    logic        iClkOrb;
    logic        reset;
    logic        iSwitch;
    logic [1:0]  iReq;
    logic [1:0]  iVal;
    logic [11:0] iData0;
    logic [11:0] iData1;
    logic [1:0]  oGnt;
    logic        oWrEn;
    logic [11:0] oWrAddr;
    logic [11:0] oWrData;
    logic        oFull;
    logic        oUnderrun;
    logic [11:0] oFillLast;

    orb_buf_fill_arb #(.W(12), .DEPTH_LOG2(11), .BURST(BURST)) dut (
        .iClkOrb   (iClkOrb),
        .reset     (reset),
        .iSwitch   (iSwitch),
        .iReq      (iReq),
        .iVal      (iVal),
        .iData0    (iData0),
        .iData1    (iData1),
        .oGnt      (oGnt),
        .oWrEn     (oWrEn),
        .oWrAddr   (oWrAddr),
        .oWrData   (oWrData),
        .oFull     (oFull),
        .oUnderrun (oUnderrun),
        .oFillLast (oFillLast)
    );

    initial iClkOrb = 1'b0;
    always #5 iClkOrb = ~iClkOrb;

    int checkCount = 0;
    int passCount  = 0;
    bit monEn      = 1'b0;

    status_t statusQ[$];
    write_t  writeQ[$];

    // Reference model: who owns the buffer, how many words it has taken, bank fill.
    int   mOwner;
    int   mPrio;
    int   mFill;
    int   mBeats;
    int   mFillLast;
    bit   mFull;
    logic mPrev;
    logic curSw;
    logic [11:0] ramp;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic failNow(input string name);
        checkCount++;
        $display("[TB] FAIL %s: condition not reached", name);
    endtask

    task automatic modelReset();
        mOwner    = -1;
        mPrio     = 0;
        mFill     = 0;
        mBeats    = 0;
        mFillLast = 0;
        mFull     = 1'b0;
        mPrev     = curSw;
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [1:0] val, input logic sw,
                                 input logic [11:0] d0, input logic [11:0] d1);
        status_t st;
        write_t  wr;
        bit      acc, swapNow;
        int      oldOwner, pick;
        iReq    = req;
        iVal    = val;
        iSwitch = sw;
        iData0  = d0;
        iData1  = d1;
        swapNow = (sw !== mPrev);
        mPrev   = sw;
        acc     = (mOwner == 0 && val[0]) || (mOwner == 1 && val[1]);
        wr.data = (mOwner == 1) ? d1 : d0;
        wr.addr = '0;
        st.underrun = 1'b0;
        if (swapNow) begin
            mFillLast   = mFill;
            st.underrun = !mFull;
            if (acc) begin
                wr.addr = {~sw, 11'd0};
                mFill   = 1;
            end else begin
                mFill = 0;
            end
            mFull  = 1'b0;
            mOwner = -1;
            mBeats = 0;
        end else begin
            oldOwner = mOwner;
            if (acc) begin
                wr.addr = {~sw, 11'(mFill)};
                mFill++;
                mBeats++;
            end
            if (oldOwner < 0) begin
                if (!mFull && req != 2'b00) begin
                    pick   = (req == 2'b11) ? mPrio : (req == 2'b01 ? 0 : 1);
                    mOwner = pick;
                    mPrio  = 1 - pick;
                    mBeats = 0;
                end
            end else if (mFill == ORB_BANK_WORDS) begin
                mFull  = 1'b1;
                mOwner = -1;
            end else if (mBeats == BURST || !req[oldOwner]) begin
                mOwner = -1;
            end
        end
        st.gnt       = (mOwner < 0) ? 2'b00 : (mOwner == 0 ? 2'b01 : 2'b10);
        st.wr_en     = acc;
        st.full      = mFull;
        st.fill_last = 12'(mFillLast);
        @(posedge iClkOrb);
        statusQ.push_back(st);
        if (acc) writeQ.push_back(wr);
        monEn = 1'b1;
        #2;
    endtask

    task automatic randomStep(input int flipOneIn);
        if (flipOneIn > 0 && $urandom_range(0, flipOneIn - 1) == 0) curSw = ~curSw;
        applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), curSw,
                      12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
    endtask

    // Scoreboard monitor: one status entry per clock edge, one write entry per oWrEn.
    always @(negedge iClkOrb) begin
        status_t s;
        write_t  w;
        if (monEn) begin
            if (statusQ.size() == 0) begin
                failNow("status_queue_empty");
            end else begin
                s = statusQ.pop_front();
                checkOutput("gnt", 32'(oGnt), 32'(s.gnt));
                checkOutput("wr_en", 32'(oWrEn), 32'(s.wr_en));
                checkOutput("full", 32'(oFull), 32'(s.full));
                checkOutput("underrun", 32'(oUnderrun), 32'(s.underrun));
                checkOutput("fill_last", 32'(oFillLast), 32'(s.fill_last));
            end
            if (oWrEn) begin
                if (writeQ.size() == 0) begin
                    failNow("write_unexpected");
                end else begin
                    w = writeQ.pop_front();
                    checkOutput("wr_addr", 32'(oWrAddr), 32'(w.addr));
                    checkOutput("wr_data", 32'(oWrData), 32'(w.data));
                end
            end
        end
    end

    initial begin
        int guard;
        reset   = 1'b0;
        curSw   = 1'b0;
        iSwitch = 1'b0;
        iReq    = 2'b00;
        iVal    = 2'b00;
        iData0  = '0;
        iData1  = '0;
        ramp    = '0;
        @(negedge iClkOrb);
        checkOutput("reset_gnt", 32'(oGnt), 32'd0);
        checkOutput("reset_wr_en", 32'(oWrEn), 32'd0);
        checkOutput("reset_full", 32'(oFull), 32'd0);
        checkOutput("reset_fill_last", 32'(oFillLast), 32'd0);
        @(posedge iClkOrb);
        #2;
        reset = 1'b1;
        modelReset();

        $display("[TB] single requester ramp");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(2'b01, 2'b01, curSw, ramp, 12'hABC);
            ramp = ramp + 1'b1;
        end

        $display("[TB] both requesters alternating");
        for (int i = 0; i < 80; i++)
            applyStimulus(2'b11, 2'b11, curSw, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));

        $display("[TB] fill to full");
        guard = 0;
        while (!mFull && guard < 20000) begin
            applyStimulus(2'b11, ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 3)), curSw,
                          12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
            guard++;
        end
        if (!mFull) failNow("fill_timeout");
        for (int i = 0; i < 20; i++)
            applyStimulus(2'b11, 2'b11, curSw, 12'h111, 12'h222);
        curSw = ~curSw;
        applyStimulus(2'b00, 2'b00, curSw, 12'h000, 12'h000);

        $display("[TB] early swap after 100 words");
        guard = 0;
        while (mFill != 100 && guard < 2000) begin
            applyStimulus(2'b11, 2'($urandom_range(0, 3)), curSw,
                          12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
            guard++;
        end
        if (mFill != 100) failNow("fill100_timeout");
        curSw = ~curSw;
        applyStimulus(2'b00, 2'b00, curSw, 12'h000, 12'h000);

        $display("[TB] swap during accepted word");
        guard = 0;
        while (mOwner != 0 && guard < 200) begin
            applyStimulus(2'b01, 2'b00, curSw, 12'h000, 12'h000);
            guard++;
        end
        if (mOwner != 0) failNow("owner0_timeout");
        curSw = ~curSw;
        applyStimulus(2'b11, 2'b11, curSw, 12'h5A5, 12'hA5A);
        for (int i = 0; i < 6; i++)
            applyStimulus(2'b11, 2'b11, curSw, 12'(12'h300 + i), 12'(12'h400 + i));

        $display("[TB] random traffic with swaps");
        for (int i = 0; i < 1500; i++) randomStep(150);

        $display("[TB] reset mid-burst");
        curSw = ~curSw;
        applyStimulus(2'b00, 2'b00, curSw, 12'h000, 12'h000);
        guard = 0;
        while (!(mOwner >= 0 && mBeats >= 3) && guard < 200) begin
            applyStimulus(2'b11, 2'b11, curSw, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
            guard++;
        end
        if (!(mOwner >= 0 && mBeats >= 3)) failNow("midburst_timeout");
        monEn = 1'b0;
        reset = 1'b0;
        #1;
        checkOutput("midrst_gnt", 32'(oGnt), 32'd0);
        checkOutput("midrst_wr_en", 32'(oWrEn), 32'd0);
        checkOutput("midrst_full", 32'(oFull), 32'd0);
        checkOutput("midrst_underrun", 32'(oUnderrun), 32'd0);
        statusQ.delete();
        writeQ.delete();
        modelReset();
        @(posedge iClkOrb);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 40; i++)
            applyStimulus(2'b11, 2'b11, curSw, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
        for (int i = 0; i < 300; i++) randomStep(100);
        for (int i = 0; i < 4; i++)
            applyStimulus(2'b00, 2'b00, curSw, 12'h000, 12'h000);

        @(negedge iClkOrb);
        checkOutput("write_queue_drained", 32'(writeQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
